painter_qsys_button_pio: RTL and testbench

Parametrised Avalon-MM input PIO for push-buttons and switches in the painter Qsys system. It replaces the fixed 4-bit key PIO and adds several features: configurable width, a per-bit debounce filter, a per-bit edge-mode register, write-1-to-clear edge capture, and a raw/debounced readback. It sits on the Nios II data master as an IRQ-capable slave.

---
 rtl/painter_qsys_button_pio.sv | 86 ++++++++
 tb/tb_painter_qsys_button_pio.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/painter_qsys_button_pio.sv
// painter_qsys_button_pio: Avalon-MM input PIO with debounce, per-bit edge modes, W1C edge capture and IRQ
module painter_qsys_button_pio #(
   parameter int          WIDTH           = 4,
   parameter int          DEBOUNCE_CYCLES = 50000,
   parameter logic [31:0] EDGE_MODE_RESET = 32'h0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [WIDTH-1:0]   sync1, sync2, stable, stable_d, rise, fall, ev;
   logic [WIDTH-1:0]   irq_mask, edge_capture, w1c;
   logic [2*WIDTH-1:0] edge_mode;
   logic [CW-1:0]      cnt [WIDTH];
   logic [31:0]        rd_mux;
   logic               we;

   assign we   = chipselect & ~write_n;
   assign rise = stable & ~stable_d;
   assign fall = ~stable & stable_d;
   assign w1c  = (we && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
   assign irq  = |(edge_capture & irq_mask);

   // Synchronise the raw inputs, then only accept a new level once it has held for DEBOUNCE_CYCLES
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         sync1    <= in_port;
         sync2    <= sync1;
         stable_d <= stable;
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == stable[i]) cnt[i] <= '0;
            else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   // Per-bit edge selection: 00 falling, 01 rising, 10 both, 11 disabled
   always_comb begin
      ev = '0;
      for (int i = 0; i < WIDTH; i++)
         ev[i] = edge_mode[2*i +: 2] == 2'b00 ? fall[i] :
                 edge_mode[2*i +: 2] == 2'b01 ? rise[i] :
                 edge_mode[2*i +: 2] == 2'b10 ? (rise[i] | fall[i]) : 1'b0;
   end

   // Read mux, zero-extended; reserved addresses read as zero
   always_comb begin
      rd_mux = address == 3'd0 ? 32'(stable)       :
               address == 3'd1 ? 32'(sync2)        :
               address == 3'd2 ? 32'(irq_mask)     :
               address == 3'd3 ? 32'(edge_capture) :
               address == 3'd4 ? 32'(edge_mode)    : 32'h0;
   end

   // Register file; a new edge wins over a same-cycle clear so no event is lost
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_mask     <= '0;
         edge_capture <= '0;
         edge_mode    <= EDGE_MODE_RESET[2*WIDTH-1:0];
         readdata     <= '0;
      end else begin
         if (we && address == 3'd2) irq_mask <= writedata[WIDTH-1:0];
         if (we && address == 3'd4) edge_mode <= writedata[2*WIDTH-1:0];
         edge_capture <= (edge_capture & ~w1c) | ev;
         readdata     <= rd_mux;
      end
   end
endmodule

// File: tb/tb_painter_qsys_button_pio.sv
// tb_painter_qsys_button_pio: directed self-checking bench for the button PIO
module tb_painter_qsys_button_pio;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'h0;
   logic [3:0]  in_port = 4'h0;
   logic [31:0] readdata;
   logic        irq;
   logic [31:0] r;
   logic        seen;
   int          checks = 0;
   int          failures = 0;

   painter_qsys_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE_RESET(32'h0)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port), .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      @(negedge clk);
      d = readdata;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      idle(3);
      chk("reset_readdata", readdata, 32'h0);
      chk("reset_irq", {31'h0, irq}, 32'h0);
      reset = 1'b0;
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), r);
         chk($sformatf("reset_read_a%0d", a), r, 32'h0);
      end
      chk("reset_irq_after", {31'h0, irq}, 32'h0);

      in_port = 4'hF;
      idle(10);
      rd(3'd0, r); chk("settle_data", r, 32'hF);
      rd(3'd3, r); chk("settle_no_capture_on_rise", r, 32'h0);
      wr(3'd2, 32'hF);
      rd(3'd2, r); chk("mask_readback", r, 32'hF);

      @(negedge clk); in_port = 4'hE; address = 3'd1;
      idle(2); chk("raw_before_sync", readdata, 32'hF);
      idle(1); chk("raw_after_sync", readdata, 32'hE);
      address = 3'd0;
      idle(1); chk("data_hold_t4", readdata, 32'hF);
      idle(2); chk("data_hold_t6", readdata, 32'hF);
      chk("irq_low_t6", {31'h0, irq}, 32'h0);
      idle(1); chk("data_change_t7", readdata, 32'hE);
      chk("irq_high_t7", {31'h0, irq}, 32'h1);
      rd(3'd3, r); chk("capture_bit0", r, 32'h1);

      wr(3'd3, 32'h1);
      chk("irq_clear_w1c", {31'h0, irq}, 32'h0);
      @(negedge clk); in_port = 4'hC;
      idle(3); in_port = 4'hE;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         seen = seen | irq;
      end
      chk("glitch_no_irq", {31'h0, seen}, 32'h0);
      rd(3'd0, r); chk("glitch_data", r, 32'hE);
      rd(3'd3, r); chk("glitch_capture", r, 32'h0);

      in_port = 4'h0;
      idle(10);
      wr(3'd3, 32'hF);
      wr(3'd4, 32'hE4);
      rd(3'd4, r); chk("edge_mode_readback", r, 32'hE4);
      rd(3'd3, r); chk("modes_start_clear", r, 32'h0);
      in_port = 4'hF;
      idle(10);
      rd(3'd3, r); chk("modes_after_rise", r, 32'h6);
      in_port = 4'h0;
      idle(10);
      rd(3'd3, r); chk("modes_after_fall", r, 32'h7);

      wr(3'd3, 32'hF);
      wr(3'd4, 32'hAA);
      in_port = 4'h3;
      idle(10);
      rd(3'd3, r); chk("w1c_setup", r, 32'h3);
      wr(3'd3, 32'h1);
      rd(3'd3, r); chk("w1c_bit0", r, 32'h2);

      @(negedge clk); in_port = 4'h7;
      idle(6);
      address = 3'd3; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
      rd(3'd3, r); chk("simul_set_clear", r, 32'h6);
      chk("irq_masked_in", {31'h0, irq}, 32'h1);
      wr(3'd2, 32'h0);
      chk("irq_mask_off", {31'h0, irq}, 32'h0);

      wr(3'd3, 32'hF);
      in_port = 4'h2;
      idle(10);
      rd(3'd3, r); chk("pre_reset_capture", r, 32'h5);
      wr(3'd2, 32'hF);
      chk("pre_reset_irq", {31'h0, irq}, 32'h1);
      @(negedge clk); in_port = 4'h0;
      idle(4);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk("mid_reset_irq", {31'h0, irq}, 32'h0);
      chk("mid_reset_readdata", readdata, 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seen = seen | irq;
      end
      chk("post_reset_no_irq", {31'h0, seen}, 32'h0);
      for (int a = 0; a < 5; a++) begin
         rd(3'(a), r);
         chk($sformatf("post_reset_a%0d", a), r, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
